writeback_unit: RTL
===================

// Module: writeback_unit
// PURPOSE
// - Final RV32I pipeline stage; drives the register file write port (wrt_en, oprd, wrt_data).
// - ALU results: accepted and written back one cycle later.
// - Loads: waits for memory read data, aligns and sign/zero-extends it, then writes it back.
// - Keeps a retired-instruction counter; flags load errors (misaligned access, bad funct3, memory timeout).
// PARAMETERS
// - TIMEOUT      16   max cycles to wait for mem_rvalid after a load is accepted (>=2)
// - CNT_W        32   width of retire_cnt
// PORTS
// - clk          in   1      system clock, all state on rising edge
// - rst          in   1      reset, asynchronous, active-low
// - in_valid     in   1      upstream holds a valid instruction result
// - in_ready     out  1      unit can accept (1 only in IDLE)
// - in_rd        in   5      destination register index
// - in_result    in   32     ALU result (ignored for loads)
// - in_wb_en     in   1      instruction writes rd
// - in_is_load   in   1      instruction is a load
// - in_funct3    in   3      load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
// - in_addr_lo   in   2      load byte address [1:0]
// - mem_rvalid   in   1      memory read data valid (1-cycle pulse)
// - mem_rdata    in   32     aligned 32-bit memory word
// - wrt_en       out  1      regfile write strobe (registered, 1-cycle pulse)
// - oprd         out  5      regfile write index (registered)
// - wrt_data     out  32     regfile write data (registered)
// - load_err     out  1      1-cycle pulse: load aborted, no write
// - retire_cnt   out  CNT_W  completed-instruction count
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; wrt_en=0, oprd=0, wrt_data=0, load_err=0, retire_cnt=0; in_ready=1 after release.
// - FSM states: IDLE, WAIT_MEM. in_ready=1 only in IDLE (combinational from state).
// - IDLE, accept (in_valid&in_ready), non-load: next cycle wrt_en=in_wb_en&&(in_rd!=0), oprd=in_rd,
//   wrt_data=in_result. retire_cnt+1 on the same edge. Stays IDLE; back-to-back acceptance each cycle.
// - IDLE, accept, load: capture rd, wb_en, funct3, addr_lo; wait counter=0; go WAIT_MEM. No write that cycle.
// - Misalignment/funct3 checked at accept: LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or funct3
//   in {011,110,111} -> next cycle load_err=1, no write, retire_cnt+1, stay IDLE (no WAIT_MEM).
// - WAIT_MEM, mem_rvalid=1: next cycle wrt_en=wb_en&&(rd!=0), oprd=rd, wrt_data=extracted value;
//   retire_cnt+1; go IDLE. Load-to-write latency = 1 cycle after mem_rvalid.
// - Extraction: byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16];
//   LB/LH sign-extend to 32, LBU/LHU zero-extend, LW = mem_rdata.
// - WAIT_MEM timeout: counter increments each cycle without mem_rvalid; at count TIMEOUT-1 with no
//   mem_rvalid -> next cycle load_err=1, no write, retire_cnt+1, go IDLE. mem_rvalid on that same
//   cycle wins (normal write, no error).
// - mem_rvalid in IDLE is ignored (late data after timeout/reset is dropped).
// - wrt_en, load_err are 1-cycle pulses; oprd/wrt_data hold last value while wrt_en=0.
// - rd=0: never asserts wrt_en; instruction still counted.
// - retire_cnt wraps 2^CNT_W-1 -> 0.
// - Reset during WAIT_MEM: abort immediately, no write, no error pulse.
// CONFIGURATION
// - WB_BYPASS_EN defined: adds inputs byp_rs1, byp_rs2 (5 bits) and outputs fwd_rs1_hit, fwd_rs2_hit (1),
//   fwd_data (32). fwd_rsX_hit = wrt_en && (oprd==byp_rsX) && (byp_rsX!=0), combinational;
//   fwd_data = wrt_data. Covers the cycle the regfile write is pending and reads still return old data.
// - WB_BYPASS_EN undefined: those ports do not exist; no forwarding logic.
// TESTING
// - ALU: in_rd=5, in_result=32'hDEADBEEF, in_wb_en=1 -> next cycle wrt_en=1, oprd=5, wrt_data=DEADBEEF, retire_cnt=1.
// - rd=0 write: in_rd=0, in_wb_en=1 -> wrt_en stays 0, retire_cnt increments.
// - LB addr_lo=3, mem_rdata=32'h80FF_0000 after 3 cycles -> wrt_data=FFFFFF80; LBU same -> 00000080;
//   in_ready=0 while waiting.
// - LH addr_lo=1 -> load_err pulse next cycle, no wrt_en, in_ready stays 1; LW addr_lo=2 same.
// - Load, no mem_rvalid for TIMEOUT cycles -> load_err=1, return IDLE; later mem_rvalid ignored.
// - WB_BYPASS_EN: ALU write rd=7, byp_rs1=7, byp_rs2=0 during wrt_en -> fwd_rs1_hit=1, fwd_rs2_hit=0, fwd_data=result.

Source files
------------

// File: rtl/writeback_unit.sv
// Final RV32I stage: writes ALU results and aligned/extended load data to the register file.
// Optional WB_BYPASS_EN adds a forwarding port for the cycle a regfile write is pending.
module writeback_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       in_rd_i,
  input  logic [31:0]      in_result_i,
  input  logic             in_wb_en_i,
  input  logic             in_is_load_i,
  input  logic [2:0]       in_funct3_i,
  input  logic [1:0]       in_addr_lo_i,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
`ifdef WB_BYPASS_EN
  input  logic [4:0]       byp_rs1_i,
  input  logic [4:0]       byp_rs2_i,
  output logic             fwd_rs1_hit_o,
  output logic             fwd_rs2_hit_o,
  output logic [31:0]      fwd_data_o,
`endif
  output logic             wrt_en_o,
  output logic [4:0]       oprd_o,
  output logic [31:0]      wrt_data_o,
  output logic             load_err_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam int unsigned WaitW = $clog2(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [4:0]         rd_q, rd_d;
  logic               wb_en_q, wb_en_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic               wrt_en_q, wrt_en_d;
  logic [4:0]         oprd_q, oprd_d;
  logic [31:0]        wrt_data_q, wrt_data_d;
  logic               load_err_q, load_err_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

  logic               load_bad;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_value;

  // Unsupported funct3 or a halfword/word address not naturally aligned.
  always_comb begin
    load_bad = 1'b0;
    case (in_funct3_i)
      3'b000, 3'b100: load_bad = 1'b0;
      3'b001, 3'b101: load_bad = in_addr_lo_i[0];
      3'b010:         load_bad = (in_addr_lo_i != 2'b00);
      default:        load_bad = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte  = mem_rdata_i[{addr_lo_q, 3'b000} +: 8];
    ld_half  = mem_rdata_i[{addr_lo_q[1], 4'b0000} +: 16];
    ld_value = mem_rdata_i;
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'h000000, ld_byte};
      3'b101:  ld_value = {16'h0000, ld_half};
      default: ld_value = mem_rdata_i;
    endcase
  end

  assign in_ready_o = (state_q == StIdle);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    rd_d         = rd_q;
    wb_en_d      = wb_en_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    wrt_en_d     = 1'b0;
    oprd_d       = oprd_q;
    wrt_data_d   = wrt_data_q;
    load_err_d   = 1'b0;
    retire_cnt_d = retire_cnt_q;

    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          if (!in_is_load_i) begin
            wrt_en_d     = in_wb_en_i && (in_rd_i != 5'd0);
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
            if (wrt_en_d) begin
              oprd_d     = in_rd_i;
              wrt_data_d = in_result_i;
            end
          end else if (load_bad) begin
            load_err_d   = 1'b1;
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
          end else begin
            rd_d       = in_rd_i;
            wb_en_d    = in_wb_en_i;
            funct3_d   = in_funct3_i;
            addr_lo_d  = in_addr_lo_i;
            wait_cnt_d = '0;
            state_d    = StWaitMem;
          end
        end
      end
      StWaitMem: begin
        // Data arriving on the final allowed cycle still beats the timeout.
        if (mem_rvalid_i) begin
          wrt_en_d     = wb_en_q && (rd_q != 5'd0);
          retire_cnt_d = retire_cnt_q + CNT_W'(1);
          state_d      = StIdle;
          if (wrt_en_d) begin
            oprd_d     = rd_q;
            wrt_data_d = ld_value;
          end
        end else if (wait_cnt_q == WaitLast) begin
          load_err_d   = 1'b1;
          retire_cnt_d = retire_cnt_q + CNT_W'(1);
          state_d      = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      rd_q         <= '0;
      wb_en_q      <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      wrt_en_q     <= 1'b0;
      oprd_q       <= '0;
      wrt_data_q   <= '0;
      load_err_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_q         <= rd_d;
      wb_en_q      <= wb_en_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      wrt_en_q     <= wrt_en_d;
      oprd_q       <= oprd_d;
      wrt_data_q   <= wrt_data_d;
      load_err_q   <= load_err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wrt_en_o     = wrt_en_q;
  assign oprd_o       = oprd_q;
  assign wrt_data_o   = wrt_data_q;
  assign load_err_o   = load_err_q;
  assign retire_cnt_o = retire_cnt_q;

`ifdef WB_BYPASS_EN
  assign fwd_rs1_hit_o = wrt_en_q && (oprd_q == byp_rs1_i) && (byp_rs1_i != 5'd0);
  assign fwd_rs2_hit_o = wrt_en_q && (oprd_q == byp_rs2_i) && (byp_rs2_i != 5'd0);
  assign fwd_data_o    = wrt_data_q;
`endif

endmodule
